aes_inv_key_sched: RTL

Sequential AES-128 round-key generator for the decryption datapath. It derives the final round key from the cipher key by running the forward schedule one round per cycle. It then streams the round keys in reverse order (round Nr down to 0) over a valid/ready handshake. It sits between the key source and the inverse-cipher core and replaces the flat 11×128-bit expanded-key bus with one 128-bit key per round.

---
 rtl/aes_inv_key_sched_pkg.sv | 47 ++++
 rtl/aes_inv_key_sched_if.sv | 25 ++
 rtl/aes_sbox_word.sv | 14 +
 rtl/aes_inv_key_sched.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/aes_inv_key_sched_pkg.sv
// Shared types and constants for the AES-128 inverse key schedule.
// Holds KEY_W/WORD_W, the FSM state enum, RCON, the S-box and RotWord.
package aes_pkg;

  localparam int KEY_W  = 128;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    REV  = 2'd2
  } state_t;

  // Index 0 is unused so that RCON[r] is the constant for round r.
  localparam logic [0:10][7:0] RCON = {
    8'h00, 8'h01, 8'h02, 8'h04,
    8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36
  };

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [WORD_W-1:0] rot_word(
    input logic [WORD_W-1:0] w
  );
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_inv_key_sched_if.sv
// Request/round-key stream bundle for aes_inv_key_sched.
// master: key source + consumer side; slave: the key scheduler.
interface aes_inv_key_sched_if;
  import aes_pkg::*;

  logic              start;
  logic [KEY_W-1:0]  key;
  logic              busy;
  logic [KEY_W-1:0]  rk;
  logic [3:0]        rk_round;
  logic              rk_valid;
  logic              rk_ready;
  logic              done;

  modport master (
    output start, key, rk_ready,
    input  busy, rk, rk_round, rk_valid, done
  );

  modport slave (
    input  start, key, rk_ready,
    output busy, rk, rk_round, rk_valid, done
  );

endinterface

// File: rtl/aes_sbox_word.sv
// Combinational 32-bit SubWord: four independent S-box byte lookups.
// Ports: din (word in), dout (substituted word out).
module aes_sbox_word
  import aes_pkg::*;
(
  input  logic [WORD_W-1:0] din,
  output logic [WORD_W-1:0] dout
);

  for (genvar i = 0; i < 4; i++) begin : g_byte
    assign dout[8*i +: 8] = SBOX[din[8*i +: 8]];
  end

endmodule

// File: rtl/aes_inv_key_sched.sv
// AES-128 round keys in reverse order: forward pass to round Nr, then
// one backward step per accepted key. Ports: clk, rst (async, high),
// bus (aes_inv_key_sched_if.slave: start/key in, rk stream out, done).
// Optional macro AES_KEY_CACHE_EN caches the last key/round-Nr pair.
module aes_inv_key_sched
  import aes_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  aes_inv_key_sched_if.slave   bus
);

  if (Nk != 4 || Nr != 10) begin : g_bad_param
    $error("aes_inv_key_sched supports only Nk=4, Nr=10");
  end

  localparam logic [3:0] NR4  = 4'(Nr);
  localparam logic [3:0] LAST = 4'(Nr - 1);

  state_t            state_q;
  state_t            state_d;
  logic [3:0]        cnt_q;
  logic [KEY_W-1:0]  w_q;
  logic [KEY_W-1:0]  rk_q;
  logic [3:0]        round_q;
  logic              valid_q;
  logic              done_q;

  logic              hs;
  logic              hit;
  logic [KEY_W-1:0]  hit_rk;

  logic              ld;
  logic              hit_ld;
  logic              fwd_en;
  logic              fwd_last;
  logic              rev_en;
  logic              rev_last;

  assign hs = valid_q & bus.rk_ready;

  // Shared SubWord datapath
  logic [WORD_W-1:0] w0, w1, w2, w3;
  logic [WORD_W-1:0] k0, k1, k2, k3;
  logic [WORD_W-1:0] n0, n1, n2, n3;
  logic [WORD_W-1:0] p0, p1, p2, p3;
  logic [WORD_W-1:0] sw_in;
  logic [WORD_W-1:0] sw_out;
  logic [WORD_W-1:0] t;
  logic [7:0]        rc;
  logic              rev_sel;
  logic [KEY_W-1:0]  fwd_w;
  logic [KEY_W-1:0]  prev_k;

  assign {w0, w1, w2, w3} = w_q;
  assign {k0, k1, k2, k3} = rk_q;

  assign rev_sel = (state_q == REV);

  assign p3 = k3 ^ k2;
  assign p2 = k2 ^ k1;
  assign p1 = k1 ^ k0;

  assign sw_in = rev_sel ? p3 : w3;
  assign rc    = rev_sel ? RCON[round_q]
                         : RCON[cnt_q + 4'd1];

  aes_sbox_word u_sbox (
    .din  (sw_in),
    .dout (sw_out)
  );

  // SubWord and RotWord commute since SubWord is bytewise.
  assign t = rot_word(sw_out) ^ {rc, 24'h0};

  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign p0 = k0 ^ t;

  assign fwd_w  = {n0, n1, n2, n3};
  assign prev_k = {p0, p1, p2, p3};

`ifdef AES_KEY_CACHE_EN
  logic              cache_valid_q;
  logic [KEY_W-1:0]  cache_key_q;
  logic [KEY_W-1:0]  cache_rk_q;

  assign hit    = cache_valid_q && (bus.key == cache_key_q);
  assign hit_rk = cache_rk_q;

  // The key is recorded at start but only marked valid once FWD
  // finishes, so a run cut short by reset never yields a hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cache_valid_q <= 1'b0;
      cache_key_q   <= '0;
      cache_rk_q    <= '0;
    end else begin
      if (ld && !hit) begin
        cache_valid_q <= 1'b0;
        cache_key_q   <= bus.key;
      end
      if (fwd_last) begin
        cache_valid_q <= 1'b1;
        cache_rk_q    <= fwd_w;
      end
    end
  end
`else
  assign hit    = 1'b0;
  assign hit_rk = '0;
`endif

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.start) state_d = hit ? REV : FWD;
      FWD:  if (cnt_q == LAST) state_d = REV;
      REV:  if (hs && round_q == 4'd0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: control outputs
  always_comb begin
    ld       = 1'b0;
    fwd_en   = 1'b0;
    fwd_last = 1'b0;
    rev_en   = 1'b0;
    rev_last = 1'b0;
    unique case (state_q)
      IDLE: ld = bus.start;
      FWD: begin
        fwd_en   = 1'b1;
        fwd_last = (cnt_q == LAST);
      end
      REV: begin
        rev_en   = hs && (round_q != 4'd0);
        rev_last = hs && (round_q == 4'd0);
      end
      default: ;
    endcase
    hit_ld = ld && hit;
  end

  // Working register, round key and stream flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      w_q     <= '0;
      rk_q    <= '0;
      round_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (ld) begin
        w_q   <= bus.key;
        cnt_q <= '0;
      end
      if (fwd_en) begin
        w_q   <= fwd_w;
        cnt_q <= cnt_q + 4'd1;
      end
      if (hit_ld) begin
        rk_q    <= hit_rk;
        round_q <= NR4;
        valid_q <= 1'b1;
      end
      if (fwd_last) begin
        rk_q    <= fwd_w;
        round_q <= NR4;
        valid_q <= 1'b1;
      end
      if (rev_en) begin
        rk_q    <= prev_k;
        round_q <= round_q - 4'd1;
      end
      if (rev_last) begin
        valid_q <= 1'b0;
        done_q  <= 1'b1;
      end
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.rk       = rk_q;
  assign bus.rk_round = round_q;
  assign bus.rk_valid = valid_q;
  assign bus.done     = done_q;

endmodule
